pcie_tx_req_mc: RTL and testbench
=================================

PCIE_TX_REQ_MC -- requirements
Module: pcie_tx_req_mc

Interface
REQ-001 SHALL have parameter P_NUM_CH, default 2: number of command channels (1..8).
REQ-002 SHALL have parameter P_SLOT_TAG_WIDTH, default 10: slot tag width.
REQ-003 SHALL have parameter C_PCIE_ADDR_WIDTH, default 48: PCIe address width.
REQ-004 SHALL have port pcie_user_clk, input, 1: sole clock. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have port pcie_user_rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pcie_max_payload_size, input, 2: MPS; 0=128 B, 1=256 B, 2 and 3=512 B.
REQ-007 SHALL have port cmd_valid, input, P_NUM_CH: per-channel command valid.
REQ-008 SHALL have port cmd_addr, input, P_NUM_CH*(C_PCIE_ADDR_WIDTH-2): per-channel DW start address, flattened with channel 0 in the LSBs.
REQ-009 SHALL have port cmd_len, input, P_NUM_CH*11: per-channel length in DWs.
REQ-010 SHALL have port cmd_slot_tag, input, P_NUM_CH*P_SLOT_TAG_WIDTH: per-channel slot tag.
REQ-011 SHALL have port cmd_ready, output, P_NUM_CH: one-hot accept pulse.
REQ-012 SHALL have the following MWr request ports:
- tx_dma_mwr_req, output, 1
- tx_dma_mwr_tag, output, 8
- tx_dma_mwr_len, output, [12:2]
- tx_dma_mwr_addr, output, [C_PCIE_ADDR_WIDTH-1:2]
- tx_dma_mwr_req_ack, input, 1
- tx_dma_mwr_data_last, input, 1
REQ-013 SHALL have the following done-report ports:
- dma_tx_done_wr_en, output, 1
- dma_tx_done_wr_data, output, P_SLOT_TAG_WIDTH+15, packed as {channel[2:0], slot_tag, len[11:0]}
- dma_tx_done_wr_rdy_n, input, 1

Function
REQ-014 SHALL use the FSM states IDLE, ARB, SPLIT, REQ, WAIT_LAST and DONE.
REQ-015 SHALL wait in IDLE until any cmd_valid bit is set, then go to ARB.
REQ-016 SHALL, in ARB, grant round-robin starting at pointer rr:
- rr resets to 0;
- after granting channel k, rr becomes (k+1) mod P_NUM_CH;
- cmd_ready[k] is high for exactly that cycle;
- the command is latched in the same cycle.
REQ-017 SHALL, in SPLIT, compute seg = min(remaining, MPS_DW, 1024 - cur_addr[11:2]) in 11-bit unsigned arithmetic, where MPS_DW is 32, 64 or 128.
REQ-018 SHALL, in REQ, hold tx_dma_mwr_req high with stable tag, len=seg and addr=cur_addr until a cycle in which tx_dma_mwr_req_ack is high; that cycle deasserts req and goes to WAIT_LAST.
REQ-019 SHALL, on tx_dma_mwr_data_last in WAIT_LAST, update remaining -= seg and cur_addr += seg, then go to SPLIT if remaining is nonzero, else to DONE.
REQ-020 SHALL make tx_dma_mwr_tag an 8-bit counter that increments on each ack and wraps 255->0.
REQ-021 SHALL, in DONE, wait while dma_tx_done_wr_rdy_n=1; with rdy_n=0, pulse dma_tx_done_wr_en for one cycle and go to IDLE.
REQ-022 SHALL, for cmd_len=0, generate no MWr, pass ARB->DONE directly, and report len=0.
REQ-023 SHALL ignore data_last outside WAIT_LAST and ack outside REQ.
REQ-024 SHALL grant no new command before DONE completes, giving at most one command in flight.
REQ-025 SHALL never let a segment cross a 4 KB address boundary or exceed MPS.

Reset
REQ-026 SHALL, on pcie_user_rst_n=0, asynchronously set the FSM to IDLE, rr=0, tag counter=0 and all outputs to 0, including a mid-transfer reset that abandons the command with no done report.

Structure
REQ-027 SHALL place the FSM state encoding and MPS_DW constants in shared package pcie_dma_pkg.
REQ-028 SHALL implement the round-robin arbiter as sub-module pcie_rr_arb (P_NUM_CH request/grant, pointer update on grant).

Verification
REQ-029 SHALL cover: MPS=0, addr=0x1000 (byte), len=100 DW -> MWr lengths 32,32,32,4; addresses 0x1000, 0x1080, 0x1100, 0x1180; one done report.
REQ-030 SHALL cover: MPS=2, byte addr 0x1F80, len=64 -> MWr lengths 32 then 32; second address 0x2000.
REQ-031 SHALL cover: both channels valid continuously -> grants 0,1,0,1, each cmd_ready a one-cycle pulse.
REQ-032 SHALL cover: ack delayed 5 cycles -> req, len and addr stable for all 6 cycles; tag increments once.
REQ-033 SHALL cover: len=0 -> no tx_dma_mwr_req; done_wr_data len field 0; with rdy_n held 3 cycles, done_wr_en follows on cycle 4.
REQ-034 SHALL cover: reset asserted in WAIT_LAST -> all outputs 0 immediately; next command begins with tag 0.

Source files
------------

// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared FSM encoding and max-payload constants for the DMA TX request path.
package pcie_dma_pkg;
  typedef enum logic [2:0] {IDLE, ARB, SPLIT, REQ, WAIT_LAST, DONE} tx_state_t;
  localparam logic [10:0] MPS_DW_128 = 11'd32;
  localparam logic [10:0] MPS_DW_256 = 11'd64;
  localparam logic [10:0] MPS_DW_512 = 11'd128;
  function automatic logic [10:0] mps_dw(input logic [1:0] mps);
    return (mps == 2'd0) ? MPS_DW_128 : (mps == 2'd1) ? MPS_DW_256 : MPS_DW_512;
  endfunction
endpackage

// File: rtl/pcie_rr_arb.sv
// pcie_rr_arb: round-robin arbiter; the pointer moves past the winner only when the grant is taken.
module pcie_rr_arb #(
  parameter int P_NUM_CH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [P_NUM_CH-1:0] req,
  input  logic                en,
  output logic [P_NUM_CH-1:0] gnt,
  output logic [2:0]          gnt_idx,
  output logic                found
);
  logic [2:0] rr;
  always_comb begin
    found = 1'b0;
    gnt_idx = 3'd0;
    for (int i = 0; i < P_NUM_CH; i++)
      for (int k = 0; k < P_NUM_CH; k++)
        if (!found && req[k] && k == (int'(rr) + i) % P_NUM_CH) begin
          found = 1'b1;
          gnt_idx = 3'(k);
        end
    gnt = '0;
    for (int k = 0; k < P_NUM_CH; k++) gnt[k] = found && gnt_idx == 3'(k);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr <= 3'd0;
    else if (en && found) rr <= (gnt_idx == 3'(P_NUM_CH - 1)) ? 3'd0 : gnt_idx + 3'd1;
endmodule

// File: rtl/pcie_tx_req_mc.sv
// pcie_tx_req_mc: arbitrates per-channel DMA write commands and splits each into MPS/4KB-safe MWr requests.
module pcie_tx_req_mc
  import pcie_dma_pkg::*;
#(
  parameter int P_NUM_CH          = 2,
  parameter int P_SLOT_TAG_WIDTH  = 10,
  parameter int C_PCIE_ADDR_WIDTH = 48
) (
  input  logic                                        pcie_user_clk,
  input  logic                                        pcie_user_rst_n,
  input  logic [1:0]                                  pcie_max_payload_size,
  input  logic [P_NUM_CH-1:0]                         cmd_valid,
  input  logic [P_NUM_CH*(C_PCIE_ADDR_WIDTH-2)-1:0]   cmd_addr,
  input  logic [P_NUM_CH*11-1:0]                      cmd_len,
  input  logic [P_NUM_CH*P_SLOT_TAG_WIDTH-1:0]        cmd_slot_tag,
  output logic [P_NUM_CH-1:0]                         cmd_ready,
  output logic                                        tx_dma_mwr_req,
  output logic [7:0]                                  tx_dma_mwr_tag,
  output logic [12:2]                                 tx_dma_mwr_len,
  output logic [C_PCIE_ADDR_WIDTH-1:2]                tx_dma_mwr_addr,
  input  logic                                        tx_dma_mwr_req_ack,
  input  logic                                        tx_dma_mwr_data_last,
  output logic                                        dma_tx_done_wr_en,
  output logic [P_SLOT_TAG_WIDTH+14:0]                dma_tx_done_wr_data,
  input  logic                                        dma_tx_done_wr_rdy_n
);
  localparam int AW = C_PCIE_ADDR_WIDTH - 2;
  tx_state_t state, nxt;
  logic [P_NUM_CH-1:0] gnt;
  logic [2:0] gnt_idx, ch;
  logic gnt_found;
  logic [AW-1:0] cur_addr, sel_addr;
  logic [10:0] rem, seg, len_r, sel_len, mps, bnd, seg_c;
  logic [P_SLOT_TAG_WIDTH-1:0] slot, sel_slot;
  logic [7:0] tag;
  pcie_rr_arb #(.P_NUM_CH(P_NUM_CH)) u_arb (
    .clk(pcie_user_clk), .rst_n(pcie_user_rst_n), .req(cmd_valid), .en(state == ARB),
    .gnt(gnt), .gnt_idx(gnt_idx), .found(gnt_found)
  );
  always_comb begin
    sel_addr = '0;
    sel_len = '0;
    sel_slot = '0;
    for (int k = 0; k < P_NUM_CH; k++)
      if (gnt[k]) begin
        sel_addr = cmd_addr[k*AW +: AW];
        sel_len = cmd_len[k*11 +: 11];
        sel_slot = cmd_slot_tag[k*P_SLOT_TAG_WIDTH +: P_SLOT_TAG_WIDTH];
      end
  end
  // Distance to the next 4 KB boundary in DWs: 1..1024.
  assign mps = mps_dw(pcie_max_payload_size);
  assign bnd = 11'd1024 - {1'b0, cur_addr[9:0]};
  assign seg_c = (rem < mps) ? ((rem < bnd) ? rem : bnd) : ((mps < bnd) ? mps : bnd);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = |cmd_valid ? ARB : IDLE;
      ARB:       nxt = !gnt_found ? IDLE : (sel_len == 11'd0) ? DONE : SPLIT;
      SPLIT:     nxt = REQ;
      REQ:       nxt = tx_dma_mwr_req_ack ? WAIT_LAST : REQ;
      WAIT_LAST: nxt = !tx_dma_mwr_data_last ? WAIT_LAST : (rem == seg) ? DONE : SPLIT;
      DONE:      nxt = dma_tx_done_wr_rdy_n ? DONE : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n)
    if (!pcie_user_rst_n) begin
      state <= IDLE;
      cur_addr <= '0;
      rem <= '0;
      seg <= '0;
      len_r <= '0;
      slot <= '0;
      ch <= '0;
      tag <= '0;
    end else begin
      state <= nxt;
      if (state == ARB && gnt_found) begin
        ch <= gnt_idx;
        len_r <= sel_len;
        rem <= sel_len;
        cur_addr <= sel_addr;
        slot <= sel_slot;
      end
      if (state == SPLIT) seg <= seg_c;
      if (state == REQ && tx_dma_mwr_req_ack) tag <= tag + 8'd1;
      if (state == WAIT_LAST && tx_dma_mwr_data_last) begin
        rem <= rem - seg;
        cur_addr <= cur_addr + AW'(seg);
      end
    end
  assign cmd_ready = (state == ARB) ? gnt : '0;
  assign tx_dma_mwr_req = state == REQ;
  assign tx_dma_mwr_tag = tag;
  assign tx_dma_mwr_len = seg;
  assign tx_dma_mwr_addr = cur_addr;
  assign dma_tx_done_wr_en = state == DONE && !dma_tx_done_wr_rdy_n;
  assign dma_tx_done_wr_data = {ch, slot, 1'b0, len_r};
endmodule

// File: tb/tb_pcie_tx_req_mc.sv
// tb_pcie_tx_req_mc: directed checks of arbitration, segment splitting, done reporting and reset.
module tb_pcie_tx_req_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mps = 2'd0;
  logic [1:0] cmd_valid = '0;
  logic [91:0] cmd_addr = '0;
  logic [21:0] cmd_len = '0;
  logic [19:0] cmd_slot_tag = '0;
  logic [1:0] cmd_ready;
  logic req;
  logic [7:0] tag;
  logic [12:2] len;
  logic [47:2] addr;
  logic ack = 1'b0;
  logic last = 1'b0;
  logic done_en;
  logic [24:0] done_data;
  logic rdy_n = 1'b0;
  logic [7:0] exp_tag = 8'd0;
  int n_chk = 0;
  int n_fail = 0;
  pcie_tx_req_mc dut (
    .pcie_user_clk(clk), .pcie_user_rst_n(rst_n), .pcie_max_payload_size(mps),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_slot_tag(cmd_slot_tag),
    .cmd_ready(cmd_ready), .tx_dma_mwr_req(req), .tx_dma_mwr_tag(tag), .tx_dma_mwr_len(len),
    .tx_dma_mwr_addr(addr), .tx_dma_mwr_req_ack(ack), .tx_dma_mwr_data_last(last),
    .dma_tx_done_wr_en(done_en), .dma_tx_done_wr_data(done_data), .dma_tx_done_wr_rdy_n(rdy_n)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic set_cmd(input int c, input logic [47:0] byte_addr, input logic [10:0] l, input logic [9:0] st);
    cmd_addr[c*46 +: 46] = byte_addr[47:2];
    cmd_len[c*11 +: 11] = l;
    cmd_slot_tag[c*10 +: 10] = st;
  endtask
  task automatic start_cmd(input int c);
    cmd_valid[c] = 1'b1;
    step();
    check("cmd_ready", cmd_ready, 64'(1 << c));
    step();
    check("ready_pulse", cmd_ready, 0);
    cmd_valid = '0;
  endtask
  task automatic wait_req();
    for (int i = 0; i < 50 && !req; i++) step();
    check("req_seen", req, 1);
  endtask
  task automatic mwr_seg(input logic [10:0] elen, input logic [47:0] ebyte, input int ack_dly);
    wait_req();
    check("mwr_len", len, elen);
    check("mwr_addr", addr, ebyte >> 2);
    check("mwr_tag", tag, exp_tag);
    for (int d = 0; d < ack_dly; d++) begin
      step();
      check("hold_req", req, 1);
      check("hold_len", len, elen);
      check("hold_addr", addr, ebyte >> 2);
      check("hold_tag", tag, exp_tag);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_tag++;
    check("req_drop", req, 0);
    check("tag_inc", tag, exp_tag);
    step();
    step();
    last = 1'b1;
    step();
    last = 1'b0;
  endtask
  task automatic wait_done(input logic [24:0] exp);
    for (int i = 0; i < 50 && !done_en; i++) step();
    check("done_seen", done_en, 1);
    check("done_data", done_data, exp);
    step();
    check("done_pulse", done_en, 0);
  endtask
  task automatic check_zero();
    check("rst_ready", cmd_ready, 0);
    check("rst_req", req, 0);
    check("rst_tag", tag, 0);
    check("rst_len", len, 0);
    check("rst_addr", addr, 0);
    check("rst_done_en", done_en, 0);
    check("rst_done_data", done_data, 0);
  endtask
  initial begin
    int grants;
    logic [1:0] prev;
    #23;
    check_zero();
    step();
    rst_n = 1'b1;
    mps = 2'd0;
    set_cmd(0, 48'h1000, 11'd100, 10'd5);
    start_cmd(0);
    mwr_seg(11'd32, 48'h1000, 0);
    mwr_seg(11'd32, 48'h1080, 0);
    mwr_seg(11'd32, 48'h1100, 0);
    mwr_seg(11'd4, 48'h1180, 0);
    wait_done({3'd0, 10'd5, 12'd100});
    for (int i = 0; i < 6; i++) begin
      step();
      check("single_done", done_en, 0);
    end
    mps = 2'd2;
    set_cmd(0, 48'h1F80, 11'd64, 10'd9);
    start_cmd(0);
    mwr_seg(11'd32, 48'h1F80, 0);
    mwr_seg(11'd32, 48'h2000, 0);
    wait_done({3'd0, 10'd9, 12'd64});
    #2 rst_n = 1'b0;
    exp_tag = 8'd0;
    #1 check("reset_tag", tag, 0);
    step();
    rst_n = 1'b1;
    set_cmd(0, 48'h0, 11'd0, 10'd1);
    set_cmd(1, 48'h0, 11'd0, 10'd2);
    rdy_n = 1'b0;
    cmd_valid = 2'b11;
    grants = 0;
    prev = '0;
    for (int i = 0; i < 40 && grants < 4; i++) begin
      step();
      if (prev != 0) check("rr_pulse", cmd_ready, 0);
      else if (cmd_ready != 0) begin
        check("rr_grant", cmd_ready, (grants % 2 == 0) ? 2'b01 : 2'b10);
        grants++;
      end
      prev = cmd_ready;
    end
    check("grant_count", grants, 4);
    step();
    cmd_valid = '0;
    for (int i = 0; i < 5; i++) step();
    mps = 2'd0;
    set_cmd(0, 48'h2000, 11'd16, 10'd7);
    start_cmd(0);
    mwr_seg(11'd16, 48'h2000, 5);
    wait_done({3'd0, 10'd7, 12'd16});
    rdy_n = 1'b1;
    set_cmd(1, 48'h3000, 11'd0, 10'd3);
    start_cmd(1);
    for (int i = 0; i < 3; i++) begin
      check("len0_wait", done_en, 0);
      check("len0_noreq", req, 0);
      step();
    end
    rdy_n = 1'b0;
    #1 check("len0_en", done_en, 1);
    check("len0_data", done_data, {3'd1, 10'd3, 12'd0});
    step();
    check("len0_pulse", done_en, 0);
    set_cmd(0, 48'h40, 11'd8, 10'd4);
    start_cmd(0);
    wait_req();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("pre_rst_tag", tag, exp_tag + 8'd1);
    #2 rst_n = 1'b0;
    exp_tag = 8'd0;
    #1 check_zero();
    step();
    rst_n = 1'b1;
    set_cmd(0, 48'h80, 11'd8, 10'd6);
    start_cmd(0);
    mwr_seg(11'd8, 48'h80, 0);
    wait_done({3'd0, 10'd6, 12'd8});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
